if_fetch_ctrl: RTL

//  Sequencing controller for the IF stage. Drives the PC register enable, the PCSrc mux select
//  and the IF/ID latch write/flush. Arbitrates between branch redirects, load-use stalls and
//  a multi-cycle instruction memory. Sits between the IF stage and the ID/EX hazard logic.

---
 rtl/if_fetch_ctrl_pkg.sv | 23 ++
 rtl/if_fetch_ctrl_timer.sv | 27 ++
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch sequencing controller: state
// encodings, the NOP pattern loaded on IF/ID flush and the default address width.
package if_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    REDIRECT = 3'd3,
    HALT_ERR = 3'd4
  } fetch_state_e;

  // Plain-vector views of the state codes for legacy tools that dislike enums.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_REDIRECT = 3'd3;
  localparam logic [2:0] ST_HALT_ERR = 3'd4;

endpackage

// File: rtl/if_fetch_ctrl_timer.sv
// Wait-cycle counter for a pending imem fetch: load to 1 on entering WAIT_MEM,
// increment while still waiting, flag when the timeout limit is reached.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic at_max
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= 8'd1;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign at_max = (cnt_reg == 8'(MAX_WAIT));

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencing controller: arbitrates branch redirects, load-use stalls and
// a multi-cycle instruction memory, driving PC enable/select and IF/ID write/flush.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              pc_we,
  output logic              pc_src,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              fetch_err,
  output logic [15:0]       stall_cycles
);

  logic [2:0] state_reg, state_next;
  logic       rpc_load, stall_inc, err_set;
  logic       timer_load, timer_inc, timer_at_max;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .inc    (timer_inc),
    .at_max (timer_at_max)
  );

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    rpc_load   = 1'b0;
    stall_inc  = 1'b0;
    err_set    = 1'b0;
    timer_load = 1'b0;
    timer_inc  = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          rpc_load   = 1'b1;
          state_next = ST_REDIRECT;
        end else if (hazard_stall) begin
          stall_inc = 1'b1;
        end else if (imem_ready) begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end else begin
          stall_inc  = 1'b1;
          timer_load = 1'b1;
          state_next = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        imem_req = 1'b1;
        // Only a clean ready without hazard advances; every other cycle is a stall.
        if (branch_taken) begin
          ifid_flush = 1'b1;
          rpc_load   = 1'b1;
          stall_inc  = 1'b1;
          state_next = ST_REDIRECT;
        end else if (imem_ready) begin
          pc_we      = !hazard_stall;
          ifid_we    = !hazard_stall;
          stall_inc  = hazard_stall;
          state_next = ST_FETCH;
        end else if (timer_at_max) begin
          stall_inc  = 1'b1;
          err_set    = 1'b1;
          state_next = ST_HALT_ERR;
        end else begin
          stall_inc = 1'b1;
          timer_inc = 1'b1;
        end
      end
      ST_REDIRECT: begin
        pc_src     = 1'b1;
        ifid_flush = 1'b1;
        if (branch_taken) begin
          rpc_load = 1'b1;
        end else begin
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT_ERR: state_next = ST_HALT_ERR;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      redirect_pc  <= RESET_PC;
      fetch_err    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_reg <= state_next;
      if (rpc_load) begin
        redirect_pc <= branch_target;
      end
      if (err_set) begin
        fetch_err <= 1'b1;
      end
      if (stall_inc && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule
